// File: rtl/tick_divider_pkg.sv
// Shared types and default constants for the tick_divider block.
package tick_divider_pkg;

  localparam int          DEF_CNT_W    = 29;
  localparam int unsigned DEF_RESET_TC = 399_999_999;

  // STOP: idle with nothing pending; RUN: counting; PEND: counting with a
  // shadow terminal count waiting for the next wrap.
  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

endpackage

// File: rtl/tick_divider_tc_compare.sv
// Equality comparator between the running counter and a terminal count.
module tc_compare #(
  parameter int CNT_W = 8
) (
  input  logic [CNT_W-1:0] a,
  input  logic [CNT_W-1:0] b,
  output logic             eq
);

  assign eq = (a == b);

endmodule

// File: rtl/tick_divider.sv
// Programmable tick divider: counts enabled cycles and pulses tick every
// TC+1 of them. A new terminal count is taken through a valid/ready
// handshake; while running it is parked in a shadow register and applied
// on the next wrap so the current period is never cut short.
// Optional build macro TICK_DIVIDER_HALF_EN adds a square-wave output half.
module tick_divider
  import tick_divider_pkg::*;
#(
  parameter int          CNT_W    = DEF_CNT_W,
  parameter int unsigned RESET_TC = DEF_RESET_TC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             tc_valid,
  input  logic [CNT_W-1:0] tc_data,
  output logic             tc_ready,
  output logic             tick,
  output logic [CNT_W-1:0] count
`ifdef TICK_DIVIDER_HALF_EN
  ,
  output logic             half
`endif
);

  localparam logic [CNT_W-1:0] RESET_TC_V = CNT_W'(RESET_TC);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] tc_act_q;
  logic [CNT_W-1:0] tc_sh_q;
  logic             at_tc;
  logic             hs;
  logic             wrap;
  logic             load_now;

  tc_compare #(.CNT_W(CNT_W)) u_cmp_wrap (
    .a  (count_q),
    .b  (tc_act_q),
    .eq (at_tc)
  );

  assign tc_ready = (state_q != ST_PEND);
  assign hs       = tc_valid & tc_ready;
  // Wrap ignores clr: a clear on the wrapping edge still releases the shadow.
  assign wrap     = en & at_tc;
  assign tick     = en & ~clr & at_tc;
  // In STOP the offered value becomes active at once and restarts the period.
  assign load_now = hs & (state_q == ST_STOP);
  assign count    = count_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_STOP;
    else        state_q <= state_d;
  end

  // Next-state logic; a RUN handshake takes precedence over en dropping so
  // the offered value is never lost.
  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: if (en) state_d = ST_RUN;
      ST_RUN: begin
        if (hs)       state_d = ST_PEND;
        else if (!en) state_d = ST_STOP;
      end
      ST_PEND: if (wrap) state_d = ST_RUN;
      default: state_d = ST_STOP;
    endcase
  end

  // Active and shadow terminal counts; reset discards any pending shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_act_q <= RESET_TC_V;
      tc_sh_q  <= '0;
    end else begin
      if (load_now)                         tc_act_q <= tc_data;
      else if (state_q == ST_PEND && wrap)  tc_act_q <= tc_sh_q;
      if (hs && state_q == ST_RUN)          tc_sh_q  <= tc_data;
    end
  end

  // Period counter: clear and immediate load restart it, en advances it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                count_q <= '0;
    else if (clr || load_now)  count_q <= '0;
    else if (en)               count_q <= at_tc ? '0 : count_q + CNT_W'(1);
  end

`ifdef TICK_DIVIDER_HALF_EN
  logic half_q;
  logic at_mid;
  logic inc;

  tc_compare #(.CNT_W(CNT_W)) u_cmp_mid (
    .a  (count_q),
    .b  (tc_act_q >> 1),
    .eq (at_mid)
  );

  // Counter advances (or wraps) normally this edge.
  assign inc = en & ~clr & ~load_now;

  // Square wave: flip at wrap and at floor(TC/2) -> +1; with TC=0 both
  // compares hit together and only the wrap flip happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      half_q <= 1'b0;
    else if (inc && (at_tc || at_mid)) half_q <= ~half_q;
  end

  assign half = half_q;
`else
  // Square-wave output not built.
`endif

endmodule

// File: tb/tb_tick_divider.sv
// Directed scoreboard bench for tick_divider (CNT_W=8, RESET_TC=4).
module tb_tick_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       tc_valid = 1'b0;
  logic [7:0] tc_data = '0;
  logic       tc_ready;
  logic       tick;
  logic [7:0] count;
`ifdef TICK_DIVIDER_HALF_EN
  logic       half;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic       tick;
    logic [7:0] count;
    logic       ready;
    logic       half_chk;
    logic       half;
  } exp_t;

  exp_t sb[$];

  tick_divider #(.CNT_W(8), .RESET_TC(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .tc_valid (tc_valid),
    .tc_data  (tc_data),
    .tc_ready (tc_ready),
    .tick     (tick),
    .count    (count)
`ifdef TICK_DIVIDER_HALF_EN
    ,
    .half     (half)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs and queue the outputs expected during it.
  task automatic step(input logic e, input logic c, input logic v, input logic [7:0] d,
                      input logic t, input logic [7:0] cnt, input logic r,
                      input logic hc = 1'b0, input logic h = 1'b0);
    exp_t x;
    en = e; clr = c; tc_valid = v; tc_data = d;
    x.tick = t; x.count = cnt; x.ready = r; x.half_chk = hc; x.half = h;
    sb.push_back(x);
    @(posedge clk); #1;
  endtask

  // Monitor: mid-cycle, compare DUT outputs against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("tick", 32'(tick), 32'(e.tick));
      check("count", 32'(count), 32'(e.count));
      check("tc_ready", 32'(tc_ready), 32'(e.ready));
`ifdef TICK_DIVIDER_HALF_EN
      if (e.half_chk) check("half", 32'(half), 32'(e.half));
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #2;
    check("rst_count", 32'(count), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_ready", 32'(tc_ready), 1);
`ifdef TICK_DIVIDER_HALF_EN
    check("rst_half", 32'(half), 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Default TC=4: tick on enabled cycles 5, 10, 15.
    for (int k = 0; k < 15; k++)
      step(1, 0, 0, 8'h00, (k % 5) == 4, 8'(k % 5), 1);

    // RUN handshake at count 2 with TC=1; tc_data wiggles afterwards.
    step(1, 0, 0, 8'h00, 0, 8'd0, 1);
    step(1, 0, 0, 8'h00, 0, 8'd1, 1);
    step(1, 0, 1, 8'h01, 0, 8'd2, 1);
    step(1, 0, 0, 8'h03, 0, 8'd3, 0);
    step(1, 0, 0, 8'h03, 1, 8'd4, 0);
    step(1, 0, 0, 8'h00, 0, 8'd0, 1);
    step(1, 0, 0, 8'h00, 1, 8'd1, 1);
    step(1, 0, 0, 8'h00, 0, 8'd0, 1);
    step(1, 0, 0, 8'h00, 1, 8'd1, 1);

    // PEND survives en=0; TC=4 applied on the following wrap.
    step(1, 0, 1, 8'h04, 0, 8'd0, 1);
    step(0, 0, 0, 8'h00, 0, 8'd1, 0);
    step(0, 0, 0, 8'h00, 0, 8'd1, 0);
    step(1, 0, 0, 8'h00, 1, 8'd1, 0);
    step(1, 0, 0, 8'h00, 0, 8'd0, 1);

    // clr at count 4: no tick, next tick five cycles later.
    step(1, 0, 0, 8'h00, 0, 8'd1, 1);
    step(1, 0, 0, 8'h00, 0, 8'd2, 1);
    step(1, 0, 0, 8'h00, 0, 8'd3, 1);
    step(1, 1, 0, 8'h00, 0, 8'd4, 1);
    for (int k = 0; k < 5; k++)
      step(1, 0, 0, 8'h00, k == 4, 8'(k), 1);

    // clr on a pending wrap: no tick, shadow TC=2 still applied.
    step(1, 0, 1, 8'h02, 0, 8'd0, 1);
    step(1, 0, 0, 8'h00, 0, 8'd1, 0);
    step(1, 0, 0, 8'h00, 0, 8'd2, 0);
    step(1, 0, 0, 8'h00, 0, 8'd3, 0);
    step(1, 1, 0, 8'h00, 0, 8'd4, 0);
    step(1, 0, 0, 8'h00, 0, 8'd0, 1);
    step(1, 0, 0, 8'h00, 0, 8'd1, 1);
    step(1, 0, 0, 8'h00, 1, 8'd2, 1);
    step(1, 0, 0, 8'h00, 0, 8'd0, 1);

    // STOP load of TC=0: forces count to 0, then tick every enabled cycle.
    step(0, 0, 0, 8'h00, 0, 8'd1, 1);
    step(0, 0, 1, 8'h00, 0, 8'd1, 1);
    step(1, 0, 0, 8'h00, 1, 8'd0, 1);
    step(1, 0, 0, 8'h00, 1, 8'd0, 1);
    step(1, 0, 0, 8'h00, 1, 8'd0, 1);
    step(1, 1, 0, 8'h00, 0, 8'd0, 1);
    step(1, 0, 0, 8'h00, 1, 8'd0, 1);

    // Enter PEND with shadow 7, then reset mid-cycle.
    step(1, 0, 1, 8'h07, 1, 8'd0, 1);
    step(0, 0, 0, 8'h00, 0, 8'd0, 0);
    en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("pend_rst_tick", 32'(tick), 0);
    check("pend_rst_ready", 32'(tc_ready), 1);
    check("pend_rst_count", 32'(count), 0);
    @(posedge clk); #1;
    check("pend_rst_hold_tick", 32'(tick), 0);
    rst_n = 1'b1;
    // Shadow discarded: period is back to RESET_TC=4.
    for (int k = 0; k < 6; k++)
      step(1, 0, 0, 8'h00, (k % 5) == 4, 8'(k % 5), 1);

`ifdef TICK_DIVIDER_HALF_EN
    // TC=5: half low for counts 0..2, high for 3..5.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step(0, 0, 1, 8'h05, 0, 8'd0, 1, 1, 0);
    for (int k = 0; k < 12; k++)
      step(1, 0, 0, 8'h00, (k % 6) == 5, 8'(k % 6), 1, 1, (k % 6) >= 3);
`endif

    en = 1'b0;
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
